// File: rtl/stage2_window_gen.sv
// stage2_window_gen: turns a raster pixel stream into a sliding KX x KY window for the stage-2 conv kernel.
module stage2_window_gen #(
   parameter int IMG_W = 12,
   parameter int IMG_H = 12,
   parameter int KX    = 5,
   parameter int KY    = 5,
   parameter int DBW   = 20
) (
   input  logic                    clk,
   input  logic                    reset_n,
   input  logic                    i_clear,
   input  logic                    i_pix_valid,
   input  logic signed [DBW-1:0]   i_pix,
   output logic                    o_win_valid,
   output logic [KX*KY*DBW-1:0]    o_win,
   output logic [7:0]              o_win_row,
   output logic [7:0]              o_win_col,
   output logic                    o_frame_done
);
   localparam int AW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
   localparam logic [7:0] COL_LAST = 8'(IMG_W - 1);
   localparam logic [7:0] ROW_LAST = 8'(IMG_H - 1);
   localparam logic [7:0] COL_MIN  = 8'(KX - 1);
   localparam logic [7:0] ROW_MIN  = 8'(KY - 1);

   logic [DBW-1:0] lb [KY-1][IMG_W];
   logic [KY*KX-1:0][DBW-1:0] win_q, win_d, out_win_q, out_win_d;
   logic [KY-1:0][DBW-1:0] new_col;
   logic [7:0] col_q, col_d, row_q, row_d, cur_col, cur_row;
   logic [7:0] out_row_q, out_row_d, out_col_q, out_col_d;
   logic valid_q, valid_d, done_q, done_d, emit;
   logic [AW-1:0] addr;

   always_comb begin
      // a clear in the same cycle as a pixel makes that pixel (0,0)
      cur_col = i_clear ? '0 : col_q;
      cur_row = i_clear ? '0 : row_q;
      addr    = cur_col[AW-1:0];
      for (int r = 0; r < KY - 1; r++)
         new_col[r] = lb[KY-2-r][addr];
      new_col[KY-1] = i_pix;
      emit  = i_pix_valid && (cur_row >= ROW_MIN) && (cur_col >= COL_MIN);
      col_d = i_pix_valid ? ((cur_col == COL_LAST) ? '0 : cur_col + 8'd1) : cur_col;
      row_d = (i_pix_valid && cur_col == COL_LAST) ? ((cur_row == ROW_LAST) ? '0 : cur_row + 8'd1) : cur_row;
      win_d = win_q;
      if (i_pix_valid) begin
         win_d = win_q >> DBW;
         for (int r = 0; r < KY; r++)
            win_d[r*KX+KX-1] = new_col[r];
      end
      valid_d   = emit;
      done_d    = emit && cur_row == ROW_LAST && cur_col == COL_LAST;
      out_win_d = emit ? win_d : out_win_q;
      out_row_d = emit ? cur_row - ROW_MIN : out_row_q;
      out_col_d = emit ? cur_col - COL_MIN : out_col_q;
   end

   always_ff @(posedge clk) begin
      if (i_pix_valid) begin
         lb[0][addr] <= i_pix;
         for (int k = 1; k < KY - 1; k++)
            lb[k][addr] <= lb[k-1][addr];
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         col_q     <= '0;
         row_q     <= '0;
         win_q     <= '0;
         out_win_q <= '0;
         out_row_q <= '0;
         out_col_q <= '0;
         valid_q   <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         col_q     <= col_d;
         row_q     <= row_d;
         win_q     <= win_d;
         out_win_q <= out_win_d;
         out_row_q <= out_row_d;
         out_col_q <= out_col_d;
         valid_q   <= valid_d;
         done_q    <= done_d;
      end
   end

   assign o_win_valid  = valid_q;
   assign o_frame_done = done_q;
   assign o_win        = out_win_q;
   assign o_win_row    = out_row_q;
   assign o_win_col    = out_col_q;
endmodule

// File: tb/tb_stage2_window_gen.sv
// tb_stage2_window_gen: table-driven and randomized checks of stage2_window_gen against a frame-array model.
module tb_stage2_window_gen;
   localparam int IMG_W = 12, IMG_H = 12, KX = 5, KY = 5, DBW = 20;
   localparam int WW = KX * KY * DBW;
   localparam int NPIX = IMG_W * IMG_H;

   logic clk = 1'b0;
   logic reset_n, i_clear, i_pix_valid;
   logic [DBW-1:0] i_pix;
   logic o_win_valid, o_frame_done;
   logic [WW-1:0] o_win;
   logic [7:0] o_win_row, o_win_col;

   stage2_window_gen #(.IMG_W(IMG_W), .IMG_H(IMG_H), .KX(KX), .KY(KY), .DBW(DBW)) dut (
      .clk(clk), .reset_n(reset_n), .i_clear(i_clear), .i_pix_valid(i_pix_valid), .i_pix(i_pix),
      .o_win_valid(o_win_valid), .o_win(o_win), .o_win_row(o_win_row), .o_win_col(o_win_col),
      .o_frame_done(o_frame_done)
   );

   always #5 clk = ~clk;

   typedef struct {
      int idx;
      bit v;
      int row, col;
      int e0, e4, e12, e20, e24;
   } vec_t;
   vec_t tbl[7];

   int n_cmp = 0, n_bad = 0;
   int p = 0, nv = 0, nd = 0;
   logic [DBW-1:0] img [IMG_H][IMG_W];
   logic [WW-1:0] last_win = '0;
   int last_row = 0, last_col = 0;

   task automatic chk(input string nm, input logic [WW-1:0] act, input logic [WW-1:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   function automatic logic [WW-1:0] el(input logic [WW-1:0] w, input int k);
      return WW'(w[k*DBW +: DBW]);
   endfunction

   task automatic count_out();
      if (o_win_valid) nv++;
      if (o_frame_done) nd++;
   endtask

   task automatic step(input logic [DBW-1:0] pix, input bit clr);
      int r, c;
      bit ev;
      logic [WW-1:0] ew;
      if (clr) p = 0;
      r = p / IMG_W;
      c = p % IMG_W;
      img[r][c] = pix;
      ev = (r >= KY - 1) && (c >= KX - 1);
      ew = '0;
      if (ev)
         for (int a = 0; a < KY; a++)
            for (int b = 0; b < KX; b++)
               ew[(a*KX+b)*DBW +: DBW] = img[r-KY+1+a][c-KX+1+b];
      i_pix = pix; i_pix_valid = 1'b1; i_clear = clr;
      @(posedge clk); #1;
      i_pix_valid = 1'b0; i_clear = 1'b0;
      count_out();
      chk("win_valid", WW'(o_win_valid), WW'(ev));
      chk("frame_done", WW'(o_frame_done), WW'(ev && p == NPIX - 1));
      if (ev) begin
         last_win = ew; last_row = r - KY + 1; last_col = c - KX + 1;
         chk("win_row", WW'(o_win_row), WW'(last_row));
         chk("win_col", WW'(o_win_col), WW'(last_col));
         chk("win_data", o_win, ew);
      end
      p = (p + 1) % NPIX;
   endtask

   task automatic idle(input int n, input bit clr);
      for (int k = 0; k < n; k++) begin
         i_clear = clr;
         @(posedge clk); #1;
         i_clear = 1'b0;
         if (clr) p = 0;
         count_out();
         chk("idle_valid", WW'(o_win_valid), '0);
         chk("idle_done", WW'(o_frame_done), '0);
         chk("idle_win_hold", o_win, last_win);
         chk("idle_row_hold", WW'(o_win_row), WW'(last_row));
         chk("idle_col_hold", WW'(o_win_col), WW'(last_col));
      end
   endtask

   task automatic do_reset();
      reset_n = 1'b0; i_clear = 1'b0; i_pix_valid = 1'b0; i_pix = '0;
      #1;
      chk("rst_valid", WW'(o_win_valid), '0);
      chk("rst_done", WW'(o_frame_done), '0);
      chk("rst_win", o_win, '0);
      chk("rst_row", WW'(o_win_row), '0);
      chk("rst_col", WW'(o_win_col), '0);
      repeat (2) @(posedge clk);
      #1 reset_n = 1'b1;
      p = 0; last_win = '0; last_row = 0; last_col = 0;
   endtask

   task automatic ramp_frame(input bit bub);
      nv = 0; nd = 0;
      for (int i = 0; i < NPIX; i++) begin
         step(DBW'(i), 1'b0);
         for (int t = 0; t < 7; t++)
            if (tbl[t].idx == i) begin
               chk("tbl_valid", WW'(o_win_valid), WW'(tbl[t].v));
               if (tbl[t].v) begin
                  chk("tbl_row", WW'(o_win_row), WW'(tbl[t].row));
                  chk("tbl_col", WW'(o_win_col), WW'(tbl[t].col));
                  chk("tbl_e0", el(o_win, 0), WW'(tbl[t].e0));
                  chk("tbl_e4", el(o_win, 4), WW'(tbl[t].e4));
                  chk("tbl_e12", el(o_win, 12), WW'(tbl[t].e12));
                  chk("tbl_e20", el(o_win, 20), WW'(tbl[t].e20));
                  chk("tbl_e24", el(o_win, 24), WW'(tbl[t].e24));
               end
            end
         if (bub) idle($urandom_range(1, 3), 1'b0);
      end
      chk("frame_windows", WW'(nv), WW'(64));
      chk("frame_done_count", WW'(nd), WW'(1));
   endtask

   initial begin
      logic [WW-1:0] all3, alln1;
      tbl[0] = '{51, 1'b0, 0, 0, 0, 0, 0, 0, 0};
      tbl[1] = '{52, 1'b1, 0, 0, 0, 4, 26, 48, 52};
      tbl[2] = '{53, 1'b1, 0, 1, 1, 5, 27, 49, 53};
      tbl[3] = '{59, 1'b1, 0, 7, 7, 11, 33, 55, 59};
      tbl[4] = '{60, 1'b0, 0, 0, 0, 0, 0, 0, 0};
      tbl[5] = '{64, 1'b1, 1, 0, 12, 16, 38, 60, 64};
      tbl[6] = '{143, 1'b1, 7, 7, 91, 95, 117, 139, 143};
      for (int k = 0; k < KX * KY; k++) all3[k*DBW +: DBW] = DBW'(3);
      alln1 = '1;
      reset_n = 1'b1; i_clear = 1'b0; i_pix_valid = 1'b0; i_pix = '0;
      #3;
      do_reset();
      idle(2, 1'b0);

      ramp_frame(1'b0);
      ramp_frame(1'b1);

      nv = 0;
      for (int i = 0; i < NPIX; i++) begin
         step('1, 1'b0);
         if (i / IMG_W >= KY - 1 && i % IMG_W >= KX - 1) chk("neg1_win", o_win, alln1);
      end
      chk("neg1_windows", WW'(nv), WW'(64));
      for (int i = 0; i < NPIX; i++) begin
         step(DBW'(3), 1'b0);
         if (i == 52) chk("pos3_first_win", o_win, all3);
      end

      for (int i = 0; i <= 70; i++) step(DBW'(i), 1'b0);
      do_reset();
      ramp_frame(1'b0);

      for (int i = 0; i < 30; i++) step(DBW'(i), 1'b0);
      for (int k = 0; k < NPIX; k++) begin
         step(DBW'(30 + k), k == 0);
         if (k == 51) chk("clr_no_valid_early", WW'(o_win_valid), '0);
         if (k == 52) begin
            chk("clr_first_valid", WW'(o_win_valid), WW'(1));
            chk("clr_e24", el(o_win, 24), WW'(82));
         end
      end

      for (int i = 0; i < 3 * NPIX; i++) begin
         step(DBW'($urandom), ($urandom_range(0, 99) == 0));
         if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2), 1'b0);
         if ($urandom_range(0, 149) == 0) idle(1, 1'b1);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/stage2_window_gen.md
Name: stage2_window_gen

Overview:
- Raster-order pixel stream in, sliding KX x KY window out.
- Producer side of the stage-2 convolution kernel window port: drives its window-valid and packed 5x5 feature-map inputs.
- Uses KY-1 line buffers plus a KY x KX register window.
- No backpressure: the kernel accepts a window every cycle.

Parameters:
- IMG_W, 12, feature-map width in pixels (must be >= KX).
- IMG_H, 12, feature-map height in pixels (must be >= KY).
- KX, 5, window width.
- KY, 5, window height.
- DBW, 20, signed pixel width (matches stage-2 conv input width).

Ports:
- clk  in  1  clock.
- reset_n  in  1  asynchronous active-low reset.
- i_clear  in  1  synchronous frame restart; zeroes counters and valid pipeline.
- i_pix_valid  in  1  pixel strobe; one pixel accepted per asserted cycle.
- i_pix  in  DBW  signed pixel, raster order (row-major, top-left first).
- o_win_valid  out  1  window valid, single-cycle per window.
- o_win  out  KX*KY*DBW  packed window; element r*KX+c at bits [(r*KX+c)*DBW +: DBW].
- o_win_row  out  8  output-map row of the current window (0..IMG_H-KY).
- o_win_col  out  8  output-map column of the current window (0..IMG_W-KX).
- o_frame_done  out  1  one-cycle pulse with the last window of a frame.

Behaviour:
- Reset (reset_n low, async):
  - o_win_valid=0, o_frame_done=0, o_win=0, o_win_row=0, o_win_col=0.
  - Column/row counters=0; window registers=0.
  - Line-buffer RAM contents are not reset.
- Counters:
  - col increments on each accepted pixel and wraps IMG_W-1 -> 0.
  - On wrap, row increments and wraps IMG_H-1 -> 0; the frame wraps automatically and the next pixel is (0,0).
- Line buffers:
  - Each accepted pixel is written at address col of buffer 0.
  - The old value at that address shifts into buffer 1, and so on through buffer KY-2.
  - The window's new right column (top to bottom) is buffer KY-2 .. buffer 0 read data, then i_pix.
- Window:
  - On each accepted pixel, the window shifts left one column and loads the new right column.
  - Element (r,c) then holds pixel (row-KY+1+r, col-KX+1+c), where (row,col) is the accepted pixel.
  - Element index 0 is top-left (oldest); index KX*KY-1 is the current pixel.
- Valid and latency:
  - o_win_valid rises exactly 1 cycle after accepting a pixel with row>=KY-1 and col>=KX-1.
  - o_win_row=row-(KY-1) and o_win_col=col-(KX-1), registered alongside.
  - At all other times o_win_valid=0; o_win, o_win_row and o_win_col hold their last values.
- Windows never straddle a row boundary: columns 0..KX-2 of each row produce no window but still fill the window registers.
- Bubbles: cycles with i_pix_valid=0 freeze the counters, window and buffers; output values are unaffected by gaps.
- o_frame_done is asserted together with o_win_valid for pixel (IMG_H-1, IMG_W-1).
- Windows per frame: (IMG_H-KY+1)*(IMG_W-KX+1), i.e. 64 at defaults.
- i_clear:
  - Sets counters to 0 and drops any pending valid/frame_done (next cycle outputs 0).
  - Window registers and line buffers are not cleared. Stale data is never exposed, because valid requires KY-1 fresh rows.
  - i_clear and i_pix_valid in the same cycle: clear wins for the counters, and the pixel is accepted as pixel (0,0) of the new frame.
- Reset mid-frame behaves like i_clear plus output zeroing; the next frame starts at (0,0).
- Arithmetic: data passes through unmodified (no rounding or saturation); the sign bit is preserved bit-exactly.

Test Plan:
- Ramp frame, i_pix = row*12+col, back-to-back valid:
  - First o_win_valid comes 1 cycle after pixel 52 (4,4), with o_win_row=0, o_win_col=0.
  - Elements: [0]=0, [4]=4, [12]=26, [20]=48, [24]=52.
- Same frame, whole-frame checks:
  - Exactly 64 valid pulses.
  - Last window has row=7, col=7, [0]=91, [24]=143.
  - o_frame_done pulses once, coincident with that last window.
- Random 1-3 cycle bubbles between pixels: window sequence, coordinates and contents match the gap-free run; no valid during bubbles.
- Frame of all -1 (0xFFFFF), then all +3, back-to-back:
  - First frame: every element of all 64 windows reads -1.
  - Second frame: its first window (after its pixel (4,4)) is all +3.
- reset_n pulsed low after pixel 70:
  - Outputs zero immediately.
  - Restarted ramp frame reproduces the first scenario exactly.
- i_clear asserted together with i_pix_valid on pixel 30:
  - That pixel becomes (0,0).
  - First valid after 52 further pixels, with [24] = value sent 52 pixels after the clear pixel.
